// File: rtl/uart_pkg.sv
// Shared constants, state encoding and frame helpers for the UART serializer path.
package uart_pkg;

    localparam int PACKET_W   = 11;
    localparam int START_IDX  = 10;
    localparam int DATA_HI    = 9;
    localparam int DATA_LO    = 2;
    localparam int PARITY_IDX = 1;
    localparam int STOP_IDX   = 0;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        SHIFT
    } state_t;

    // Odd parity covers the data byte plus the parity bit itself.
    function automatic logic odd_parity_ok(input logic [PACKET_W-1:0] packet);
        return ^packet[DATA_HI:PARITY_IDX];
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/uart_serializer.sv
// Shifts a framed UART packet out on tx, one bit per uart_clock rising edge,
// after optionally validating start, stop and odd parity.
module uart_serializer
    import uart_pkg::*;
#(
    parameter int   PACKET_W    = uart_pkg::PACKET_W,
    parameter logic IDLE_LEVEL  = 1'b1,
    parameter bit   CHECK_FRAME = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_clock,
    input  logic [PACKET_W-1:0] uart_packet,
    input  logic                startTransmit,
    output logic                tx,
    output logic                busy,
    output logic                done,
    output logic                frame_err
);

    localparam int                CNT_W    = $clog2(PACKET_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PACKET_W);

    state_t              r_state;
    logic [PACKET_W-1:0] r_shreg;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic                r_start_q;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;
    logic                r_frame_err;

    logic                w_tick;
    logic                w_start_edge;
    logic                w_frame_ok;

    sync_edge_detect u_baud (
        .clk     (clk),
        .rst     (rst),
        .i_async (uart_clock),
        .o_rise  (w_tick)
    );

    assign w_start_edge = startTransmit & ~r_start_q;
    assign w_frame_ok   = !CHECK_FRAME ||
                          ((uart_packet[PACKET_W-1] == 1'b0) &&
                           (uart_packet[STOP_IDX] == 1'b1) &&
                           odd_parity_ok(uart_packet));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_start_q   <= 1'b0;
            r_tx        <= IDLE_LEVEL;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_start_q   <= startTransmit;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A tick arriving with the request is left alone so the
                    // start bit always gets a full period from the next tick.
                    if (w_start_edge) begin
                        if (w_frame_ok) begin
                            r_shreg <= uart_packet;
                            r_busy  <= 1'b1;
                            r_state <= ALIGN;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                ALIGN: begin
                    if (w_tick) begin
                        r_tx      <= r_shreg[PACKET_W-1];
                        r_shreg   <= {r_shreg[PACKET_W-2:0], 1'b0};
                        r_bit_cnt <= CNT_W'(1);
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (r_bit_cnt < LAST_CNT) begin
                            r_tx      <= r_shreg[PACKET_W-1];
                            r_shreg   <= {r_shreg[PACKET_W-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else begin
                            r_tx    <= IDLE_LEVEL;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_serializer.sv
// Scoreboard bench for uart_serializer: stimulus queues expected frames/errors,
// a monitor decodes tx like a UART receiver and checks done/frame_err pulses.
module tb_uart_serializer;

    localparam int UP    = 16;
    localparam int NBITS = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_clock = 1'b0;
    logic [10:0] uart_packet = '0;
    logic        startTransmit = 1'b0;
    logic        tx;
    logic        busy;
    logic        done;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int ndone  = 0;

    logic [10:0] exp_frames[$];
    logic [10:0] exp_errs[$];

    uart_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .uart_clock    (uart_clock),
        .uart_packet   (uart_packet),
        .startTransmit (startTransmit),
        .tx            (tx),
        .busy          (busy),
        .done          (done),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (UP / 2) @(posedge clk);
            #1 uart_clock = ~uart_clock;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Frame built from a byte and a defect kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop.
    function automatic logic [10:0] make_pkt(input logic [7:0] data, input int kind);
        int   ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += int'(data[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        if (kind == 1) par = ~par;
        return {(kind == 2) ? 1'b1 : 1'b0, data, par, (kind == 3) ? 1'b0 : 1'b1};
    endfunction

    // Monitor: receiver-style decode of tx sampled mid-bit, plus pulse checks.
    logic        m_prev_tx = 1'b1;
    logic        m_prev_uart = 1'b0;
    logic        m_active = 1'b0;
    int          m_cyc = 0;
    int          m_fall = 0;
    int          m_nsamp = 0;
    logic [10:0] m_bits = '0;

    always @(negedge clk) begin
        m_cyc++;
        if (rst) begin
            m_active    = 1'b0;
            m_nsamp     = 0;
            m_prev_tx   = 1'b1;
            m_prev_uart = uart_clock;
        end else begin
            if (done && frame_err) chk("done_and_err_overlap", 1, 0);
            if (frame_err) begin
                if (exp_errs.size() == 0) chk("unexpected_frame_err", 1, 0);
                else begin
                    void'(exp_errs.pop_front());
                    chk("frame_err_expected", 1, 1);
                end
            end
            if (!m_active && m_prev_tx && !tx) begin
                m_active = 1'b1;
                m_fall   = m_cyc;
                m_nsamp  = 0;
            end
            if (m_active && m_prev_uart && !uart_clock && m_nsamp < NBITS) begin
                m_bits = {m_bits[9:0], tx};
                m_nsamp++;
                if (m_nsamp == NBITS) begin
                    if (exp_frames.size() == 0) chk("unexpected_frame", int'(m_bits), -1);
                    else chk("frame_bits", int'(m_bits), int'(exp_frames.pop_front()));
                end
            end
            if (done) begin
                ndone++;
                if (!m_active) chk("done_without_frame", 1, 0);
                else begin
                    chk("frame_len_cycles", m_cyc - m_fall, NBITS * UP);
                    chk("bits_before_done", m_nsamp, NBITS);
                end
                m_active = 1'b0;
            end
            m_prev_tx   = tx;
            m_prev_uart = uart_clock;
        end
    end

    task automatic request(input logic [10:0] p, input bit acc, input bit err,
                           input bit was_busy, input int hold);
        @(posedge clk);
        #1;
        uart_packet   = p;
        startTransmit = 1'b1;
        if (acc) begin
            exp_frames.push_back(p);
            n_acc++;
        end
        if (err) exp_errs.push_back(p);
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_request", int'(busy), int'(acc || was_busy));
        repeat (hold) @(posedge clk);
        #1;
        startTransmit = 1'b0;
        uart_packet   = 11'($urandom);
    endtask

    task automatic wait_idle();
        repeat (13 * UP) @(posedge clk);
    endtask

    initial begin
        logic [10:0] p;
        int          kind;
        bit          ok;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Valid A5 frame; busy must hold mid-frame.
        request(11'b0_10100101_1_1, 1, 0, 0, 2);
        repeat (5) @(posedge uart_clock);
        @(negedge clk);
        chk("busy_mid_frame", int'(busy), 1);
        wait_idle();
        chk("busy_after_frame", int'(busy), 0);

        // Malformed: parity, start bit, stop bit. tx must stay idle.
        request(make_pkt(8'h0F, 1), 0, 1, 0, 2);
        repeat (20) @(posedge uart_clock);
        @(negedge clk);
        chk("tx_idle_after_err", int'(tx), 1);
        request(11'b1_10100101_1_1, 0, 1, 0, 2);
        wait_idle();
        request(11'b0_10100101_1_0, 0, 1, 0, 2);
        wait_idle();

        // Retrigger while busy is dropped.
        request(make_pkt(8'h3C, 0), 1, 0, 0, 2);
        repeat (5) @(posedge uart_clock);
        request(make_pkt(8'hC3, 0), 0, 0, 1, 2);
        wait_idle();

        // Level held for three frame times triggers once.
        request(make_pkt(8'h5A, 0), 1, 0, 0, 3 * NBITS * UP);
        wait_idle();

        // Reset in the sixth bit aborts without done; next frame is clean.
        request(make_pkt(8'hE7, 0), 1, 0, 0, 2);
        repeat (6) @(posedge uart_clock);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(exp_frames.pop_back());
        n_acc--;
        @(negedge clk);
        chk("rst_mid_tx", int'(tx), 1);
        chk("rst_mid_busy", int'(busy), 0);
        repeat (3 * UP) @(posedge clk);
        request(11'b0_10100101_1_1, 1, 0, 0, 2);
        wait_idle();

        // Request lands in the same cycle as a tick: start bit waits for the next tick.
        @(posedge uart_clock);
        @(posedge clk);
        request(make_pkt(8'h81, 0), 1, 0, 0, 1);
        @(negedge uart_clock);
        chk("coincide_tx_still_idle", int'(tx), 1);
        @(negedge uart_clock);
        chk("coincide_start_bit", int'(tx), 0);
        wait_idle();

        // Randomized mix of good/bad frames with occasional retriggers.
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 5);
            if (kind > 3) kind = 0;
            ok = (kind == 0);
            p  = make_pkt(8'($urandom), kind);
            request(p, ok, !ok, 0, $urandom_range(1, 30));
            if (ok && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 8)) @(posedge uart_clock);
                request(make_pkt(8'($urandom), $urandom_range(0, 3)), 0, 0, 1, 2);
            end
            wait_idle();
        end

        wait_idle();
        chk("done_count", ndone, n_acc);
        chk("frames_outstanding", exp_frames.size(), 0);
        chk("errs_outstanding", exp_errs.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_serializer.md
Name: uart_serializer

Overview:
- Downstream stage of the packet builder: accepts the 11-bit framed UART packet and its start strobe, then shifts the frame out serially on a single TX line at the UART bit rate.
- Bit timing comes from the external uart_clock, which is synchronised and edge-detected into a one-cycle baud tick in the clk domain.
- Validates frame structure (start bit, stop bit, odd parity) before sending.
- Reports busy, done and frame-error status.

Parameters:
- PACKET_W, 11, frame width. Packet layout: [10] start, [9:2] data, [1] parity, [0] stop.
- IDLE_LEVEL, 1, TX line level when idle and during reset.
- CHECK_FRAME, 1, 1 = validate the frame before sending; 0 = send any packet unchecked.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- uart_clock  input  1  bit-rate clock, asynchronous to clk
- uart_packet  input  PACKET_W  framed packet, bit 10 transmitted first
- startTransmit  input  1  level from upstream; its rising edge requests a send
- tx  output  1  serial line
- busy  output  1  high from request acceptance until the frame completes
- done  output  1  one-cycle pulse when the stop bit period ends
- frame_err  output  1  one-cycle pulse when a request is rejected as malformed

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - tx=IDLE_LEVEL, busy=0, done=0, frame_err=0, state=IDLE.
  - Synchroniser flops, edge-history flops, shift register and bit counter all clear.
  - Reset mid-frame aborts the frame immediately; tx returns to idle on the next edge; done is not pulsed.
- Tick generation:
  - uart_clock passes through a 2-flop synchroniser (s1, s2) and a history flop s3.
  - tick = s2 & ~s3, so each uart_clock rising edge produces exactly one tick cycle.
- Start detection:
  - start_edge = startTransmit & ~start_q, where start_q is registered every cycle.
  - Upstream holds startTransmit high after asserting it, so only the edge counts. A held level never retriggers.
- States: IDLE, ALIGN, SHIFT.
  - IDLE, on start_edge:
    - If CHECK_FRAME=1 and any check fails → frame_err=1 for the next cycle; stay IDLE; tx unchanged. Checks: packet[10]==0; packet[0]==1; XOR of packet[9:1]==1 (odd parity over data+parity).
    - Otherwise, at the same edge: capture packet into shreg, busy=1, state=ALIGN.
  - ALIGN, on tick: tx=shreg[10], shift left, bit_cnt=1, state=SHIFT. tx stays idle until this tick, so the start bit always lasts a full bit period.
  - SHIFT, on tick:
    - If bit_cnt<PACKET_W → tx=shreg[10], shift, bit_cnt+1.
    - If bit_cnt==PACKET_W (stop bit has lasted a full period) → tx=IDLE_LEVEL, busy=0, done=1 for one cycle, state=IDLE.
- Frame length: exactly PACKET_W ticks from the first tx transition to the return to idle. Each bit holds for one tick interval.
- Simultaneous / ignored events:
  - start_edge while busy is ignored and lost; no queueing, no error.
  - start_edge and tick in the same cycle in IDLE: the request is accepted and the tick is not consumed, so the next tick drives the start bit.
  - uart_packet is sampled only at acceptance; later changes have no effect on the frame in flight.
- bit_cnt is 4 bits wide and does not wrap within one frame.
- done and frame_err are never both asserted.

Decomposition:
- Shared package uart_pkg:
  - constants PACKET_W=11, START_IDX=10, PARITY_IDX=1, STOP_IDX=0, DATA_HI=9, DATA_LO=2
  - state enum {IDLE, ALIGN, SHIFT}
  - function odd_parity_ok(packet)
- One natural sub-module, sync_edge_detect: 2-flop synchroniser plus rising-edge pulse, with clk and rst. Instantiated for uart_clock. Reusable by upstream blocks for button inputs.

Test Plan:
- Valid frame: packet 0b0_10100101_1_1 (data A5, four ones, parity 1), start edge, uart_clock at 1/16 clk → tx sequence across ticks 0,1,0,1,0,0,1,0,1,1,1 then idle 1; busy high throughout; done pulses once after the 11th bit period.
- Parity error: data 0x0F with parity 0 → frame_err pulses one cycle; busy stays 0; tx stays 1 through the next 20 ticks. Repeat with start bit 1, and separately with stop bit 0 → frame_err each time.
- Retrigger while busy: second start edge at tick 5 with a different packet → first frame completes unchanged; no second frame; single done.
- Held level: startTransmit held high for 3 frame times after one edge → exactly one frame, one done.
- Reset mid-frame: assert rst during the 6th bit → tx=1 and busy=0 on the next edge; no done. A new start after reset sends a complete, correct frame.
- Start and tick coincide in IDLE → start bit begins on the following tick, not the coincident one; total frame still lasts 11 tick intervals.
